// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg -- shared definitions for the iomem_ac_responder slice.
//   * FSM state encoding (OFF=0, IDLE=1, COOL=2, HEAT=3)
//   * register window offsets
//   * register reset values
//   * byte_merge(): applies per-lane write strobes to a 32-bit word
// ---------------------------------------------------------------------------
package ac_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_COOL = 2'd2,
        ST_HEAT = 2'd3
    } ac_state_e;

    localparam logic [7:0] OFS_CTRL     = 8'h00;
    localparam logic [7:0] OFS_SETPOINT = 8'h04;
    localparam logic [7:0] OFS_HYST     = 8'h08;
    localparam logic [7:0] OFS_TEMP     = 8'h0C;
    localparam logic [7:0] OFS_STATUS   = 8'h10;
    localparam logic [7:0] OFS_DUTY     = 8'h14;
    localparam logic [7:0] OFS_IRQ_STAT = 8'h18;

    localparam logic        CTRL_EN_RST  = 1'b0;
    localparam logic [11:0] SETPOINT_RST = 12'h190;
    localparam logic [7:0]  HYST_RST     = 8'h08;
    localparam logic [11:0] TEMP_RST     = 12'h000;
    localparam logic [31:0] DUTY_RST     = 32'h0000_0080;
    localparam logic [1:0]  IRQ_STAT_RST = 2'b00;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ac_pwm_gen.sv
// ---------------------------------------------------------------------------
// ac_pwm_gen -- free-running fan PWM counter and duty comparator.
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   en_i     in   counter runs (wrapping) while high, held at 0 while low
//   duty_i   in   PWM_BITS duty value; output high for duty_i of 2**PWM_BITS
//   pwm_o    out  registered PWM output, 0 whenever en_i is low
// ---------------------------------------------------------------------------
module ac_pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] cnt_q;
    logic                pwm_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
            pwm_q <= (cnt_q < duty_i);
        end else begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/iomem_ac_responder.sv
// ---------------------------------------------------------------------------
// iomem_ac_responder -- memory-mapped air-conditioning controller on a
// picorv32-style iomem bus (valid/ready handshake, one-cycle ack).
//
// Ports:
//   clk, resetn                    clock / asynchronous active-low reset
//   iomem_valid/ready              request / single-cycle acknowledge
//   iomem_wstrb/addr/wdata/rdata   byte strobes (0 = read), address, data
//   temp_in, temp_stb              temperature code and its load strobe
//   cool_on, heat_on, fan_pwm      actuator drives
//   irq                            level interrupt (0 unless AC_IRQ_EN)
//
// Register window (BASE_ADDR[31:8]): 0x00 CTRL, 0x04 SETPOINT, 0x08 HYST,
// 0x0C TEMP (RO), 0x10 STATUS (RO), 0x14 DUTY, 0x18 IRQ_STAT (W1C).
//
// Build option: define AC_IRQ_EN to add IRQ_STAT and the irq output.
// ---------------------------------------------------------------------------
module iomem_ac_responder
    import ac_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int unsigned PWM_BITS  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic [11:0] temp_in,
    input  logic        temp_stb,
    output logic        cool_on,
    output logic        heat_on,
    output logic        fan_pwm,
    output logic        irq
);

    logic                sel;
    logic                acc;
    logic                wr;
    logic [7:0]          ofs;

    logic                ready_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rd_mux;
    logic [31:0]         irq_rd;

    logic                en_q;
    logic [11:0]         sp_q;
    logic [7:0]          hyst_q;
    logic [11:0]         temp_q;
    logic [PWM_BITS-1:0] duty_q;

    ac_state_e           state_q, state_d;
    logic                cool_q, heat_q;

    logic [12:0]         hi_sum;
    logic [12:0]         lo_diff;
    logic [11:0]         thr_hi;
    logic [11:0]         thr_lo;

    // Access is taken on the first edge that samples sel; ready_q blocks a
    // second ack on the following edge while the master still holds valid.
    assign sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign acc = sel && !ready_q;
    assign wr  = acc && (|iomem_wstrb);
    assign ofs = iomem_addr[7:0];

    // ---------------------------------------------------------------- IRQ
`ifdef AC_IRQ_EN
    logic [1:0] irq_stat_q, irq_stat_d;
    logic [1:0] irq_set, irq_clr;

    always_comb begin
        irq_set    = {(state_d == ST_HEAT) && (state_q != ST_HEAT),
                      (state_d == ST_COOL) && (state_q != ST_COOL)};
        irq_clr    = (wr && ofs == OFS_IRQ_STAT && iomem_wstrb[0]) ? iomem_wdata[1:0] : 2'b00;
        // set wins over a same-cycle W1C clear
        irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_stat_q <= IRQ_STAT_RST;
        end else begin
            irq_stat_q <= irq_stat_d;
        end
    end

    assign irq_rd = 32'(irq_stat_q);
    assign irq    = |irq_stat_q;
`else
    assign irq_rd = '0;
    assign irq    = 1'b0;
`endif

    // ------------------------------------------------------------ readback
    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_CTRL:     rd_mux = 32'(en_q);
            OFS_SETPOINT: rd_mux = 32'(sp_q);
            OFS_HYST:     rd_mux = 32'(hyst_q);
            OFS_TEMP:     rd_mux = 32'(temp_q);
            OFS_STATUS:   rd_mux = 32'(state_q);
            OFS_DUTY:     rd_mux = 32'(duty_q);
            OFS_IRQ_STAT: rd_mux = irq_rd;
            default:      rd_mux = '0;
        endcase
    end

    // ------------------------------------------------- bus + register file
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            en_q    <= CTRL_EN_RST;
            sp_q    <= SETPOINT_RST;
            hyst_q  <= HYST_RST;
            temp_q  <= TEMP_RST;
            duty_q  <= DUTY_RST[PWM_BITS-1:0];
        end else begin
            ready_q <= acc;
            rdata_q <= acc ? rd_mux : '0;
            if (temp_stb) begin
                temp_q <= temp_in;
            end
            if (wr) begin
                case (ofs)
                    OFS_CTRL:     en_q   <= iomem_wstrb[0] ? iomem_wdata[0] : en_q;
                    OFS_SETPOINT: sp_q   <= 12'(byte_merge(32'(sp_q), iomem_wdata, iomem_wstrb));
                    OFS_HYST:     hyst_q <= 8'(byte_merge(32'(hyst_q), iomem_wdata, iomem_wstrb));
                    OFS_DUTY:     duty_q <= PWM_BITS'(byte_merge(32'(duty_q), iomem_wdata, iomem_wstrb));
                    default:      ;
                endcase
            end
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;

    // ---------------------------------------------------------- thresholds
    // 13-bit sums so the band edges clamp to 0 / 4095 instead of wrapping.
    always_comb begin
        hi_sum  = {1'b0, sp_q} + {5'b0, hyst_q};
        lo_diff = {1'b0, sp_q} - {5'b0, hyst_q};
        thr_hi  = hi_sum[12]  ? 12'hFFF : hi_sum[11:0];
        thr_lo  = lo_diff[12] ? 12'h000 : lo_diff[11:0];
    end

    // ----------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        if (!en_q) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:  state_d = ST_IDLE;
                ST_IDLE: begin
                    if (temp_q > thr_hi) begin
                        state_d = ST_COOL;
                    end else if (temp_q < thr_lo) begin
                        state_d = ST_HEAT;
                    end
                end
                ST_COOL: if (temp_q <= sp_q) state_d = ST_IDLE;
                ST_HEAT: if (temp_q >= sp_q) state_d = ST_IDLE;
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_OFF;
            cool_q  <= 1'b0;
            heat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= (state_d == ST_COOL);
            heat_q  <= (state_d == ST_HEAT);
        end
    end

    assign cool_on = cool_q;
    assign heat_on = heat_q;

    // ----------------------------------------------------------------- PWM
    ac_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .resetn (resetn),
        .en_i   ((state_q == ST_COOL) || (state_q == ST_HEAT)),
        .duty_i (duty_q),
        .pwm_o  (fan_pwm)
    );

endmodule

// File: doc/iomem_ac_responder.md
IOMEM_AC_RESPONDER -- requirements
Module: iomem_ac_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000: 256-byte register window base, bits [7:0] ignored.
REQ-002 SHALL have parameter PWM_BITS, default 8: width of the fan PWM counter and the duty register.
REQ-003 SHALL have port clk, input, 1: the single clock; all flops are rising-edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port iomem_valid, input, 1: request from the SoC.
REQ-006 SHALL have port iomem_ready, output, 1: completion acknowledge.
REQ-007 SHALL have port iomem_wstrb, input, 4: byte write strobes; all zero means read.
REQ-008 SHALL have port iomem_addr, input, 32: byte address.
REQ-009 SHALL have port iomem_wdata, input, 32: write data.
REQ-010 SHALL have port iomem_rdata, output, 32: read data.
REQ-011 SHALL have port temp_in, input, 12: unsigned temperature code.
REQ-012 SHALL have port temp_stb, input, 1: single-cycle strobe marking temp_in valid.
REQ-013 SHALL have ports cool_on, heat_on and fan_pwm, output, 1 each: actuator drives.
REQ-014 SHALL have port irq, output, 1: level interrupt.

Function
REQ-015 SHALL decode sel = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8]; when sel is low, iomem_ready SHALL stay low.
REQ-016 SHALL assert iomem_ready for exactly one cycle, in the cycle after sel is first sampled high; iomem_rdata SHALL be valid only in that cycle and SHALL be 0 otherwise.
REQ-017 SHALL commit writes in the ready cycle, per byte lane per wstrb; if valid drops before ready, there SHALL be no side effect and no ready.
REQ-018 SHALL implement these offsets: 0x00 CTRL (bit0 EN, RW); 0x04 SETPOINT (12b, RW); 0x08 HYST (8b, RW); 0x0C TEMP (12b, RO); 0x10 STATUS (bits[1:0] state, RO); 0x14 DUTY (PWM_BITS, RW); 0x18 IRQ_STAT (bits[1:0], W1C).
REQ-019 SHALL return 0 for reads of unmapped offsets and ignore writes to them, while still acknowledging the access.
REQ-020 SHALL latch temp_in into TEMP on temp_stb; the FSM SHALL evaluate with the latched TEMP.
REQ-021 SHALL implement FSM states OFF=0, IDLE=1, COOL=2, HEAT=3.
REQ-022 SHALL take these FSM transitions:
- any state -> OFF when EN=0.
- OFF -> IDLE when EN=1.
- IDLE -> COOL when TEMP > SETPOINT+HYST.
- IDLE -> HEAT when TEMP < SETPOINT-HYST.
- COOL -> IDLE when TEMP <= SETPOINT.
- HEAT -> IDLE when TEMP >= SETPOINT.
REQ-023 SHALL compute thresholds in 13-bit arithmetic, saturating at 0 and 4095.
REQ-024 SHALL drive cool_on=1 only in COOL and heat_on=1 only in HEAT, both registered.
REQ-025 SHALL run the PWM counter freely, wrapping, only in COOL or HEAT, and hold it at 0 otherwise.
REQ-026 SHALL drive fan_pwm = (cnt < DUTY) in COOL or HEAT, and 0 otherwise.
REQ-027 SHALL give DUTY=0 -> fan_pwm constant 0 and DUTY=255 -> fan_pwm high 255 of 256 cycles.
REQ-028 SHALL let a same-cycle CTRL write and temp_stb both take effect; the FSM SHALL use the new values in the next cycle.

Reset
REQ-029 SHALL, on resetn low, asynchronously clear the following:
- iomem_ready=0, iomem_rdata=0.
- CTRL=0, SETPOINT=0x190, HYST=0x08, TEMP=0, DUTY=0x80, IRQ_STAT=0.
- state=OFF, cnt=0, cool_on=heat_on=fan_pwm=irq=0.
REQ-030 SHALL abort any in-flight access on reset mid-transaction, with no write committed.

Configuration
REQ-031 SHALL, with AC_IRQ_EN defined:
- set IRQ_STAT[0] on entry to COOL and IRQ_STAT[1] on entry to HEAT.
- drive irq = |IRQ_STAT.
- give a same-cycle set priority over W1C clear.
REQ-032 SHALL, without AC_IRQ_EN, tie irq to 0, read offset 0x18 as 0, and implement no IRQ_STAT flops.

Structure
REQ-033 SHALL keep the register offsets, the state encoding and the reset values in the shared package ac_pkg.
REQ-034 SHALL place the PWM counter and comparator in the sub-module ac_pwm_gen.

Verification
REQ-035 SHALL cover: read 0x03000004 after reset -> ready one cycle after valid, rdata=0x00000190.
REQ-036 SHALL cover: write 0x0000ABCD to 0x14 with wstrb=4'b0001 -> DUTY reads 0xCD.
REQ-037 SHALL cover: EN=1, SETPOINT=0x190, HYST=8, temp_stb with 0x199 -> COOL, cool_on=1; then 0x190 -> IDLE.
REQ-038 SHALL cover: SETPOINT=4, HYST=8, TEMP=0 -> saturated threshold 0, stays IDLE.
REQ-039 SHALL cover: COOL with DUTY=64 -> fan_pwm high 64 of every 256 cycles; EN=0 -> OFF, fan_pwm=0.
REQ-040 SHALL cover, with AC_IRQ_EN: HEAT entry -> irq=1; write 0x2 to 0x18 -> irq=0; an access to 0x04000000 -> no ready.
